mul6_mac_acc: RTL and testbench



---
 rtl/mul6_pkg.sv | 14 +
 rtl/mul6_pp_array.sv | 23 ++
 rtl/mul6_mac_acc.sv | 136 +++++++++++++
 tb/tb_mul6_mac_acc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul6_pkg.sv
// Shared constants and FSM state type for the mul6 multiply-accumulate slice.
package mul6_pkg;

  localparam int OPND_W = 6;
  localparam int PROD_W = 12;

  // ACCUM takes operand pairs, FLUSH drains the last pair, RESULT offers the sum.
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FLUSH  = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/mul6_pp_array.sv
// Purely combinational 6x6 unsigned partial-product multiplier.
module mul6_pp_array
  import mul6_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] a_ext;

  assign a_ext = {{(PROD_W-OPND_W){1'b0}}, a};

  // Sum one shifted copy of the multiplicand for every set multiplier bit.
  always_comb begin
    // NOTE: blocking assignments here; p is a running total rebuilt every evaluation.
    p = '0;
    for (int i = 0; i < OPND_W; i++) begin
      if (b[i]) p = p + (a_ext << i);
    end
  end

endmodule

// File: rtl/mul6_mac_acc.sv
// Frame-based multiply-accumulate stage wrapping mul6_pp_array.
// Operand pairs are registered (stage 1), multiplied and accumulated (stage 2);
// the frame closed by in_last is reported as sum / beat count / overflow.
// Build option: define MUL6_MAC_SAT_EN to clamp the accumulator at 2^ACC_W-1
// instead of wrapping; out_ovf is set in both cases.
module mul6_mac_acc
  import mul6_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t state, state_nxt;

  // Stage 1 operand registers.
  logic [OPND_W-1:0] a_q, b_q;
  logic              last_q;
  logic              v1;

  // Stage 2 datapath.
  logic [PROD_W-1:0] p;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ACC_W:0]    sum;
  logic              wrap;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_r;

  logic accept;
  logic fin;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  // The last pair of a frame is always in stage 2 during FLUSH.
  assign fin      = (state == FLUSH) && v1 && last_q;

  mul6_pp_array u_pp (
    .a (a_q),
    .b (b_q),
    .p (p)
  );

  assign sum  = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, p};
  assign wrap = sum[ACC_W];

`ifdef MUL6_MAC_SAT_EN
  assign acc_nxt = wrap ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in every clocked block so all registers
    // update from the same pre-edge values.
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = RESULT;
      RESULT:  if (out_valid && out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Stage 1: capture an accepted pair; v1 marks it for stage 2 next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are reset too, so a mid-frame reset leaves no stale pair.
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      v1     <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a_q    <= in_a;
        b_q    <= in_b;
        last_q <= in_last;
      end
    end
  end

  // Stage 2: accumulate the product and count beats; clear when the frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (fin) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (v1) begin
      acc   <= acc_nxt;
      cnt   <= cnt + CNT_W'(1);
      ovf_r <= ovf_r | wrap;
    end
  end

  // Result register: loaded as the last pair is accumulated, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (fin) begin
      out_valid <= 1'b1;
      out_sum   <= acc_nxt;
      out_count <= cnt + CNT_W'(1);
      out_ovf   <= ovf_r | wrap;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul6_mac_acc.sv
// Self-checking bench for mul6_mac_acc: a default instance (ACC_W=20, CNT_W=8)
// and a narrow instance (ACC_W=12, CNT_W=2) share one stimulus stream.
module tb_mul6_mac_acc;

`ifdef MUL6_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [19:0] sum_a;
    logic [7:0]  cnt_a;
    logic        ovf_a;
    logic [11:0] sum_b;
    logic [1:0]  cnt_b;
    logic        ovf_b;
  } exp_t;

  typedef struct {
    int              n;
    logic [7:0][5:0] a;
    logic [7:0][5:0] b;
    exp_t            e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  in_a, in_b;
  logic        in_last;
  logic        out_ready;
  logic        ready_a, ready_b, valid_a, valid_b;
  logic [19:0] sum_a;
  logic [7:0]  cnt_a;
  logic        ovf_a;
  logic [11:0] sum_b;
  logic [1:0]  cnt_b;
  logic        ovf_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  mul6_mac_acc dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_a),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(valid_a),
    .out_ready(out_ready), .out_sum(sum_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  mul6_mac_acc #(.ACC_W(12), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_b),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(valid_b),
    .out_ready(out_ready), .out_sum(sum_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Offer one pair from a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic last,
                      output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!ready_a && waits <= 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits > 50) fail("accept_timeout");
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 6'($urandom);
    in_b     = 6'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Waits from the negedge inside FLUSH: checks 2-cycle latency and the 2-cycle ready gap.
  task automatic check_latency(input string tag);
    check({tag, "_valid_flush"}, 32'(valid_a), 32'd0);
    check({tag, "_ready_flush"}, 32'(ready_a), 32'd0);
    @(negedge clk);
    check({tag, "_valid_result"}, 32'(valid_a), 32'd1);
    check({tag, "_valid_b_result"}, 32'(valid_b), 32'd1);
    check({tag, "_ready_result"}, 32'(ready_a), 32'd0);
    @(negedge clk);
    check({tag, "_ready_back"}, 32'(ready_a), 32'd1);
    check({tag, "_ready_b_back"}, 32'(ready_b), 32'd1);
  endtask

  // Scoreboard: compare every taken result against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (rst_n && valid_a && out_ready) begin
      if (q.size() == 0) begin
        fail("unexpected_result");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum_a",   32'(sum_a),   32'(e.sum_a));
        check("count_a", 32'(cnt_a),   32'(e.cnt_a));
        check("ovf_a",   32'(ovf_a),   32'(e.ovf_a));
        check("valid_b", 32'(valid_b), 32'd1);
        check("sum_b",   32'(sum_b),   32'(e.sum_b));
        check("count_b", 32'(cnt_b),   32'(e.cnt_b));
        check("ovf_b",   32'(ovf_b),   32'(e.ovf_b));
      end
    end
  end

  initial begin
    int w;
    exp_t e;

    // Frame table; packed element [0] is the first pair of the frame.
    vecs[0].n = 1; vecs[0].a = 48'(6'd63); vecs[0].b = 48'(6'd63);
    vecs[0].e = '{20'd3969, 8'd1, 1'b0, 12'd3969, 2'd1, 1'b0};
    vecs[1].n = 4;
    vecs[1].a = 48'({6'd0, 6'd63, 6'd2, 6'd1});
    vecs[1].b = 48'({6'd5, 6'd63, 6'd3, 6'd1});
    vecs[1].e = '{20'd3976, 8'd4, 1'b0, 12'd3976, 2'd0, 1'b0};
    vecs[2].n = 2; vecs[2].a = 48'({6'd63, 6'd63}); vecs[2].b = 48'({6'd63, 6'd63});
    vecs[2].e = '{20'd7938, 8'd2, 1'b0, (SAT ? 12'd4095 : 12'd3842), 2'd2, 1'b1};
    vecs[3].n = 5;
    vecs[3].a = 48'({6'd1, 6'd1, 6'd1, 6'd1, 6'd1});
    vecs[3].b = 48'({6'd1, 6'd1, 6'd1, 6'd1, 6'd1});
    vecs[3].e = '{20'd5, 8'd5, 1'b0, 12'd5, 2'd1, 1'b0};
    vecs[4].n = 3;
    vecs[4].a = 48'({6'd63, 6'd63, 6'd63}); vecs[4].b = 48'({6'd63, 6'd63, 6'd63});
    vecs[4].e = '{20'd11907, 8'd3, 1'b0, (SAT ? 12'd4095 : 12'd3715), 2'd3, 1'b1};
    vecs[5].n = 8;
    vecs[5].a = {6'd5, 6'd33, 6'd1, 6'd7, 6'd63, 6'd0, 6'd20, 6'd10};
    vecs[5].b = {6'd13, 6'd2, 6'd0, 6'd7, 6'd1, 6'd9, 6'd5, 6'd20};
    vecs[5].e = '{20'd543, 8'd8, 1'b0, 12'd543, 2'd0, 1'b0};

    // Reset state.
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_ready",  32'(ready_a), 32'd1);
    check("rst_valid",  32'(valid_a), 32'd0);
    check("rst_sum",    32'(sum_a),   32'd0);
    check("rst_count",  32'(cnt_a),   32'd0);
    check("rst_ovf",    32'(ovf_a),   32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table frames; odd entries insert an idle cycle after every non-last pair.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].a[i], vecs[v].b[i], (i == vecs[v].n - 1), w);
        if ((v % 2 == 1) && (i != vecs[v].n - 1)) @(negedge clk);
      end
      q.push_back(vecs[v].e);
      check_latency($sformatf("vec%0d", v));
    end

    // Backpressure: result held for 5 cycles, then the next frame goes in at once.
    out_ready = 1'b0;
    for (int i = 0; i < vecs[1].n; i++)
      send(vecs[1].a[i], vecs[1].b[i], (i == vecs[1].n - 1), w);
    q.push_back(vecs[1].e);
    w = 0;
    while (!valid_a && w < 10) begin @(negedge clk); w++; end
    if (!valid_a) fail("bp_valid_timeout");
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(valid_a), 32'd1);
      check("bp_ready", 32'(ready_a), 32'd0);
      check("bp_sum",   32'(sum_a),   32'd3976);
      check("bp_count", 32'(cnt_a),   32'd4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(6'd63, 6'd63, 1'b1, w);
    check("bp_accept_wait", 32'(w), 32'd1);
    q.push_back(vecs[0].e);
    check_latency("bp_next");

    // Reset while a result waits: it must never be delivered.
    out_ready = 1'b0;
    send(6'd3, 6'd3, 1'b1, w);
    @(negedge clk);
    check("rr_valid_before", 32'(valid_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_valid", 32'(valid_a), 32'd0);
    check("rr_ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-frame after two pairs, then a single-beat frame.
    send(6'd1, 6'd1, 1'b0, w);
    send(6'd2, 6'd2, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check("rf_ready", 32'(ready_a), 32'd1);
    check("rf_valid", 32'(valid_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(6'd2, 6'd2, 1'b1, w);
    e = '{20'd4, 8'd1, 1'b0, 12'd4, 2'd1, 1'b0};
    q.push_back(e);
    check_latency("rf");

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
